kdf_hirose_present_iter: RTL and testbench

Parametrised, handshaked successor to the single-block Hirose/PRESENT KDF. It derives a key of KEY_BLOCKS×128 bits from password, salt and iteration count. It runs one hirose_present_wrapper instance repeatedly and supports chained or XOR-accumulate iteration. It sits between the password/salt front end and the key store or cipher key port, and adds start/abort control and a multi-block output.

---
 rtl/kdf_pkg.sv | 39 +++
 rtl/hirose_present_wrapper.sv | 88 ++++++++
 rtl/kdf_hirose_present_iter_block_engine.sv | 83 ++++++++
 rtl/kdf_hirose_present_iter.sv | 134 +++++++++++++
 tb/tb_kdf_hirose_present_iter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/kdf_pkg.sv
// Shared types and helpers for the iterated Hirose/PRESENT key derivation.
// Contents: FSM state enum, iteration-mode codes, block index width, and
// the builder for the first hash input of a key block.
package kdf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HRST,
    HWAIT,
    ACC,
    NEXT,
    DONE
  } kdf_state_t;

  localparam int unsigned MODE_CHAINED  = 0;
  localparam int unsigned MODE_XOR      = 1;
  localparam int unsigned BLK_IDX_WIDTH = 8;
  localparam int unsigned HASH_WIDTH    = 128;
  localparam int unsigned VEC_MAX_WIDTH = 1024;

  typedef logic [VEC_MAX_WIDTH-1:0] vec_t;

  // Packs {password, salt, count, block index} into the LSBs of a wide vector.
  // Callers pass zero-extended fields and truncate the result to their width.
  function automatic vec_t first_block_vec(input vec_t pw, input vec_t salt,
                                           input int unsigned salt_w,
                                           input vec_t count,
                                           input int unsigned count_w,
                                           input logic [BLK_IDX_WIDTH-1:0] blk);
    vec_t v;
    v = pw;
    v = (v << salt_w) | salt;
    v = (v << count_w) | count;
    v = (v << BLK_IDX_WIDTH) | VEC_MAX_WIDTH'(blk);
    return v;
  endfunction

endpackage

// File: rtl/hirose_present_wrapper.sv
// Hirose double-block-length hash over PRESENT-128, one cipher round per cycle.
// The message is zero-padded to 64-bit chunks; chunk k is data_in[64k +: 64].
// Ports: clk; rst (active-high sync, restarts the hash); data_in (held stable
// while hashing); hash_out = {G, H}; end_signal stays high once hash_out is final.
module hirose_present_wrapper #(
  parameter int unsigned DW     = 136,
  parameter logic [63:0] HASH_C = 64'h1234567812345678
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_in,
  output logic [127:0]  hash_out,
  output logic          end_signal
);

  localparam int unsigned NCH = (DW + 63) / 64;
  localparam int unsigned PW  = NCH * 64;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;

  function automatic logic [63:0] present_round(input logic [63:0] s, input logic [63:0] rk);
    logic [63:0] x;
    logic [63:0] y;
    x = s ^ rk;
    for (int n = 0; n < 16; n++) x[4*n +: 4] = SBOX[{x[4*n +: 4], 2'b00} +: 4];
    y = '0;
    for (int j = 0; j < 63; j++) y[(16*j) % 63] = x[j];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [127:0] key_update(input logic [127:0] k, input logic [4:0] rc);
    logic [127:0] r;
    r = {k[66:0], k[127:67]};
    r[127:124] = SBOX[{r[127:124], 2'b00} +: 4];
    r[123:120] = SBOX[{r[123:120], 2'b00} +: 4];
    r[66:62]   = r[66:62] ^ rc;
    return r;
  endfunction

  logic [PW-1:0]  padded;
  logic [63:0]    g, h, sg, sh;
  logic [127:0]   key;
  logic [5:0]     rnd;
  logic [CW-1:0]  chunk;
  logic           load;

  assign padded   = PW'(data_in);
  assign hash_out = {g, h};

  // Both Hirose encryptions share the key H||M and run side by side.
  always_ff @(posedge clk) begin
    if (rst) begin
      g          <= '0;
      h          <= '0;
      sg         <= '0;
      sh         <= '0;
      key        <= '0;
      rnd        <= '0;
      chunk      <= '0;
      load       <= 1'b1;
      end_signal <= 1'b0;
    end else if (load) begin
      key  <= {h, padded[{chunk, 6'd0} +: 64]};
      sg   <= g;
      sh   <= g ^ HASH_C;
      rnd  <= 6'd1;
      load <= 1'b0;
    end else if (!end_signal) begin
      if (rnd <= 6'd31) begin
        sg  <= present_round(sg, key[127:64]);
        sh  <= present_round(sh, key[127:64]);
        key <= key_update(key, rnd[4:0]);
        rnd <= rnd + 6'd1;
      end else begin
        g <= sg ^ key[127:64] ^ g;
        h <= sh ^ key[127:64] ^ g ^ HASH_C;
        if (chunk == CW'(NCH - 1)) begin
          end_signal <= 1'b1;
        end else begin
          chunk <= chunk + CW'(1);
          load  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/kdf_hirose_present_iter_block_engine.sv
// Derives one 128-bit key block: LOAD/HRST/HWAIT/ACC loop over the hash core.
// Ports: clk; rst (active-low sync); start (begin a block, clears acc);
// abort (return to IDLE, hash core held in reset); first_vec (first hash
// input); ce (effective iteration count); acc (block result);
// iter_index (current iteration); done_c (final ACC cycle of the block).
module kdf_block_engine
  import kdf_pkg::*;
#(
  parameter int unsigned DW          = 136,
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned MODE        = 0,
  parameter logic [63:0] HASH_C      = 64'h1234567812345678
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DW-1:0]          first_vec,
  input  logic [COUNT_WIDTH-1:0] ce,
  output logic [HASH_WIDTH-1:0]  acc,
  output logic [COUNT_WIDTH-1:0] iter_index,
  output logic                   done_c
);

  kdf_state_t            state;
  logic [DW-1:0]         hash_in;
  logic [HASH_WIDTH-1:0] hash_out;
  logic                  hash_end;
  logic                  hash_rst;

  // Core is restarted in HRST and kept in reset during a system reset or abort.
  assign hash_rst = ~rst | abort | (state == HRST);
  assign done_c   = (state == ACC) && (iter_index == ce);

  hirose_present_wrapper #(
    .DW     (DW),
    .HASH_C (HASH_C)
  ) u_hash (
    .clk        (clk),
    .rst        (hash_rst),
    .data_in    (hash_in),
    .hash_out   (hash_out),
    .end_signal (hash_end)
  );

  // hash_in doubles as the previous-output register between iterations.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      hash_in    <= '0;
      acc        <= '0;
      iter_index <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc   <= '0;
          state <= LOAD;
        end
        LOAD: begin
          iter_index <= COUNT_WIDTH'(1);
          hash_in    <= first_vec;
          state      <= HRST;
        end
        HRST:  state <= HWAIT;
        HWAIT: if (hash_end) state <= ACC;
        ACC: begin
          acc <= (MODE == MODE_XOR) ? (acc ^ hash_out) : hash_out;
          if (iter_index == ce) begin
            state <= IDLE;
          end else begin
            iter_index <= iter_index + COUNT_WIDTH'(1);
            hash_in    <= DW'(hash_out);
            state      <= HRST;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/kdf_hirose_present_iter.sv
// Iterated Hirose/PRESENT KDF producing KEY_BLOCKS x 128-bit key material.
// Ports: clk; rst (active-low sync); start/abort control; salt, count,
// user_password (latched on accepted start); ready/busy status; done (pulse
// with the final block); key_valid; key_derivated (block 0 in LSBs);
// iter_index (debug, iteration within current block).
module kdf_hirose_present_iter
  import kdf_pkg::*;
#(
  parameter int unsigned SALT_WIDTH  = 64,
  parameter int unsigned PSW_WIDTH   = 32,
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned KEY_BLOCKS  = 2,
  parameter int unsigned MODE        = 0,
  parameter logic [63:0] HASH_C      = 64'h1234567812345678
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic [SALT_WIDTH-1:0]            salt,
  input  logic [COUNT_WIDTH-1:0]           count,
  input  logic [PSW_WIDTH-1:0]             user_password,
  output logic                             ready,
  output logic                             busy,
  output logic                             done,
  output logic                             key_valid,
  output logic [HASH_WIDTH*KEY_BLOCKS-1:0] key_derivated,
  output logic [COUNT_WIDTH-1:0]           iter_index
);

  localparam int unsigned DW = PSW_WIDTH + SALT_WIDTH + COUNT_WIDTH + BLK_IDX_WIDTH;

  if (DW < 128 || KEY_BLOCKS < 1 || KEY_BLOCKS > 255) begin : g_param_check
    $error("kdf_hirose_present_iter: DW must be >= 128 and KEY_BLOCKS in 1..255");
  end

  kdf_state_t                 state;
  logic [SALT_WIDTH-1:0]      salt_q;
  logic [COUNT_WIDTH-1:0]     count_q;
  logic [PSW_WIDTH-1:0]       pw_q;
  logic [BLK_IDX_WIDTH-1:0]   blk;
  logic [COUNT_WIDTH-1:0]     ce;
  logic [DW-1:0]              first_vec;
  logic [HASH_WIDTH-1:0]      eng_acc;
  logic                       eng_start;
  logic                       eng_abort;
  logic                       eng_done;
  logic                       last_blk;

  assign ce        = (count_q == '0) ? COUNT_WIDTH'(1) : count_q;
  assign first_vec = DW'(first_block_vec(VEC_MAX_WIDTH'(pw_q), VEC_MAX_WIDTH'(salt_q), SALT_WIDTH,
                                         VEC_MAX_WIDTH'(count_q), COUNT_WIDTH, blk));
  assign last_blk  = (blk == BLK_IDX_WIDTH'(KEY_BLOCKS - 1));
  // Engine launch is combinational so it enters LOAD together with the top.
  assign eng_start = ((state == IDLE) && start) || ((state == NEXT) && !last_blk);
  assign eng_abort = abort && (state != IDLE);

  kdf_block_engine #(
    .DW          (DW),
    .COUNT_WIDTH (COUNT_WIDTH),
    .MODE        (MODE),
    .HASH_C      (HASH_C)
  ) u_eng (
    .clk        (clk),
    .rst        (rst),
    .start      (eng_start),
    .abort      (eng_abort),
    .first_vec  (first_vec),
    .ce         (ce),
    .acc        (eng_acc),
    .iter_index (iter_index),
    .done_c     (eng_done)
  );

  // Top sequencer: LOAD here stands for "engine working on block blk".
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      ready         <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      key_valid     <= 1'b0;
      key_derivated <= '0;
      salt_q        <= '0;
      count_q       <= '0;
      pw_q          <= '0;
      blk           <= '0;
    end else if (eng_abort) begin
      state         <= IDLE;
      ready         <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      key_valid     <= 1'b0;
      key_derivated <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          salt_q    <= salt;
          count_q   <= count;
          pw_q      <= user_password;
          key_valid <= 1'b0;
          blk       <= '0;
          ready     <= 1'b0;
          busy      <= 1'b1;
          state     <= LOAD;
        end
        LOAD: if (eng_done) state <= NEXT;
        NEXT: begin
          key_derivated[{blk, 7'd0} +: HASH_WIDTH] <= eng_acc;
          if (last_blk) begin
            done      <= 1'b1;
            key_valid <= 1'b1;
            state     <= DONE;
          end else begin
            blk   <= blk + BLK_IDX_WIDTH'(1);
            state <= LOAD;
          end
        end
        DONE: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kdf_hirose_present_iter.sv
`timescale 1ns/1ps
module tb_kdf_hirose_present_iter;

  localparam logic [63:0] HC = 64'h1234567812345678;
  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  logic clk;
  logic rst;
  logic st0, ab0, st1, ab1;
  logic [63:0] salt;
  logic [31:0] count, pw;
  logic ready0, busy0, done0, kv0;
  logic ready1, busy1, done1, kv1;
  logic [255:0] key0;
  logic [127:0] key1;
  logic [31:0] it0, it1;

  int checks = 0;
  int errors = 0;
  int runs0 = 0, runs1 = 0, dones0 = 0, dones1 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  kdf_hirose_present_iter #(.SALT_WIDTH(64), .PSW_WIDTH(32), .COUNT_WIDTH(32),
                            .KEY_BLOCKS(2), .MODE(0), .HASH_C(HC)) u0 (
    .clk(clk), .rst(rst), .start(st0), .abort(ab0), .salt(salt), .count(count),
    .user_password(pw), .ready(ready0), .busy(busy0), .done(done0), .key_valid(kv0),
    .key_derivated(key0), .iter_index(it0));

  kdf_hirose_present_iter #(.SALT_WIDTH(64), .PSW_WIDTH(32), .COUNT_WIDTH(32),
                            .KEY_BLOCKS(1), .MODE(1), .HASH_C(HC)) u1 (
    .clk(clk), .rst(rst), .start(st1), .abort(ab1), .salt(salt), .count(count),
    .user_password(pw), .ready(ready1), .busy(busy1), .done(done1), .key_valid(kv1),
    .key_derivated(key1), .iter_index(it1));

  // Observation of hash-core completions and done pulses.
  always @(posedge u0.u_eng.u_hash.end_signal) runs0++;
  always @(posedge u1.u_eng.u_hash.end_signal) runs1++;
  always @(posedge clk) begin
    if (done0) dones0++;
    if (done1) dones1++;
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [127:0] k_in);
    logic [63:0] s, t;
    logic [127:0] k;
    s = pt;
    k = k_in;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[127:64];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
      t = '0;
      for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (b * 16) % 63] = s[b];
      s = t;
      k = {k[66:0], k[127:67]};
      k[127:124] = SB[k[127:124]];
      k[123:120] = SB[k[123:120]];
      k[66:62] = k[66:62] ^ 5'(r);
    end
    return s ^ k[127:64];
  endfunction

  function automatic logic [127:0] hash_model(input logic [191:0] msg);
    logic [63:0] g, h, gn, m;
    logic [127:0] kk;
    g = '0;
    h = '0;
    for (int c = 0; c < 3; c++) begin
      m  = msg[64*c +: 64];
      kk = {h, m};
      gn = present_enc(g, kk) ^ g;
      h  = present_enc(g ^ HC, kk) ^ g ^ HC;
      g  = gn;
    end
    return {g, h};
  endfunction

  function automatic logic [127:0] block_model(input logic [31:0] p, input logic [63:0] s,
                                               input logic [31:0] c, input logic [7:0] b,
                                               input int mode);
    logic [127:0] u, t;
    longint ce;
    ce = (c == 0) ? 1 : longint'(c);
    u = hash_model({56'd0, p, s, c, b});
    t = u;
    for (longint i = 2; i <= ce; i++) begin
      u = hash_model({64'd0, u});
      t = (mode == 1) ? (t ^ u) : u;
    end
    return t;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int which, input logic [31:0] p, input logic [63:0] s,
                             input logic [31:0] c, input logic with_abort);
    pw = p;
    salt = s;
    count = c;
    if (which == 0) begin st0 = 1'b1; ab0 = with_abort; end
    else begin st1 = 1'b1; ab1 = with_abort; end
    @(negedge clk);
    st0 = 1'b0; st1 = 1'b0; ab0 = 1'b0; ab1 = 1'b0;
  endtask

  // Waits for done, checks key_valid rises with it and the return to ready.
  task automatic wait_done(input int which, input int budget, input string tag);
    logic seen, prev_kv, d, kv;
    seen = 1'b0;
    prev_kv = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      d  = (which == 0) ? done0 : done1;
      kv = (which == 0) ? kv0 : kv1;
      if (d) begin
        seen = 1'b1;
        check({tag, "_kv_at_done"}, 256'(kv), 256'(1));
        check({tag, "_kv_low_before"}, 256'(prev_kv), 256'(0));
      end
      prev_kv = kv;
    end
    check({tag, "_done_seen"}, 256'(seen), 256'(1));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 256'((which == 0) ? done0 : done1), 256'(0));
    check({tag, "_ready_after"}, 256'((which == 0) ? ready0 : ready1), 256'(1));
  endtask

  task automatic run0(input logic [31:0] p, input logic [63:0] s, input logic [31:0] c,
                      input string tag);
    int r0, d0, ce;
    ce = (c == 0) ? 1 : int'(c);
    r0 = runs0;
    d0 = dones0;
    pulse_start(0, p, s, c, 1'b0);
    wait_done(0, 150 * ce * 2 + 100, tag);
    check({tag, "_key"}, key0, {block_model(p, s, c, 8'd1, 0), block_model(p, s, c, 8'd0, 0)});
    check({tag, "_runs"}, 256'(runs0 - r0), 256'(ce * 2));
    check({tag, "_done_count"}, 256'(dones0 - d0), 256'(1));
  endtask

  task automatic run1(input logic [31:0] p, input logic [63:0] s, input logic [31:0] c,
                      input logic with_abort, input string tag);
    int r1, d1, ce;
    ce = (c == 0) ? 1 : int'(c);
    r1 = runs1;
    d1 = dones1;
    pulse_start(1, p, s, c, with_abort);
    wait_done(1, 150 * ce + 100, tag);
    check({tag, "_key"}, 256'(key1), 256'(block_model(p, s, c, 8'd0, 1)));
    check({tag, "_runs"}, 256'(runs1 - r1), 256'(ce));
    check({tag, "_done_count"}, 256'(dones1 - d1), 256'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] p;
    logic [63:0] s;
    logic [31:0] c;
    logic reached;
    int base, d0;

    rst = 1'b0;
    st0 = 1'b0; ab0 = 1'b0; st1 = 1'b0; ab1 = 1'b0;
    pw = '0; salt = '0; count = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 256'(ready0), 256'(1));
    check("rst_busy", 256'(busy0), 256'(0));
    check("rst_kv", 256'(kv0), 256'(0));
    check("rst_key", key0, 256'(0));
    check("rst_iter", 256'(it0), 256'(0));
    check("rst_ready1", 256'(ready1), 256'(1));
    rst = 1'b1;
    @(negedge clk);

    // Single block, one iteration: key = H({pw, salt, 1, 0}).
    run1(32'hDEADBEEF, 64'h0123456789ABCDEF, 32'd1, 1'b0, "single");

    // Two blocks, chained, count=3.
    run0(32'hDEADBEEF, 64'h0123456789ABCDEF, 32'd3, "chain3");
    check("chain3_blocks_differ", 256'(key0[255:128] != key0[127:0]), 256'(1));

    // Reset in the middle of a derivation.
    pulse_start(0, $urandom, {$urandom, $urandom}, 32'd5, 1'b0);
    repeat (150) @(negedge clk);
    check("midrst_busy_before", 256'(busy0), 256'(1));
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 256'(ready0), 256'(1));
    check("midrst_busy", 256'(busy0), 256'(0));
    check("midrst_kv", 256'(kv0), 256'(0));
    check("midrst_key", key0, 256'(0));
    check("midrst_done", 256'(done0), 256'(0));
    rst = 1'b1;
    @(negedge clk);

    // XOR-accumulate, count=4, then count=0 runs a single iteration.
    p = $urandom; s = {$urandom, $urandom};
    run1(p, s, 32'd4, 1'b0, "xor4");
    run1(p, s, 32'd0, 1'b0, "xor0");
    run1(p, s, 32'd1, 1'b0, "xor1");
    // start and abort together in IDLE: start wins.
    run1($urandom, {$urandom, $urandom}, 32'd1, 1'b1, "start_wins");

    // Second start while busy and input changes are ignored.
    p = $urandom; s = {$urandom, $urandom};
    d0 = dones0;
    pulse_start(0, p, s, 32'd2, 1'b0);
    repeat (20) @(negedge clk);
    pulse_start(0, ~p, ~s, 32'd1, 1'b0);
    pw = $urandom; salt = {$urandom, $urandom}; count = 32'd7;
    wait_done(0, 800, "busy_start");
    check("busy_start_key", key0, {block_model(p, s, 32'd2, 8'd1, 0), block_model(p, s, 32'd2, 8'd0, 0)});
    check("busy_start_done_count", 256'(dones0 - d0), 256'(1));

    // Abort during block 1 with count=10.
    d0 = dones0;
    base = runs0;
    pulse_start(0, $urandom, {$urandom, $urandom}, 32'd10, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 3000 && !reached; i++) begin
      @(negedge clk);
      if (runs0 >= base + 11) reached = 1'b1;
    end
    check("abort_reach_blk1", 256'(reached), 256'(1));
    check("abort_busy_before", 256'(busy0), 256'(1));
    ab0 = 1'b1;
    @(negedge clk);
    ab0 = 1'b0;
    check("abort_ready", 256'(ready0), 256'(1));
    check("abort_busy", 256'(busy0), 256'(0));
    check("abort_kv", 256'(kv0), 256'(0));
    check("abort_key", key0, 256'(0));
    repeat (5) @(negedge clk);
    check("abort_no_done", 256'(dones0 - d0), 256'(0));
    run0($urandom, {$urandom, $urandom}, 32'd2, "after_abort");

    // Randomized derivations on both configurations.
    for (int k = 0; k < 3; k++) begin
      p = $urandom; s = {$urandom, $urandom}; c = $urandom_range(0, 3);
      run0(p, s, c, "rand0");
      p = $urandom; s = {$urandom, $urandom}; c = $urandom_range(0, 4);
      run1(p, s, c, 1'b0, "rand1");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
